therm_ramp_gen: RTL

Sequential thermometer-code generator for the combinational datapath benchmarks. It accepts a target level through a valid/ready handshake and slews a registered WIDTH-bit thermometer word toward that level, one bit per clock. The output is therefore always a legal monotone code (bits [level-1:0] set, the rest clear), as the downstream thermometer/all-ones/all-zeros checkers require. It also reports end-of-ramp and all-ones/all-zeros status.

---
 rtl/therm_ramp_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/therm_ramp_gen.sv
// Thermometer ramp generator: slews a registered WIDTH-bit thermometer code toward an accepted target, one level per clock.
// Optional macro THERM_RAMP_SELFCHECK_EN adds the sticky err output driven by an internal code/step checker.
module therm_ramp_gen #(
  parameter int WIDTH = 16,
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [LVL_W-1:0] tgt_level,
  input  logic             hold,
  output logic [WIDTH-1:0] therm_out,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             done,
  output logic             all_ones,
`ifdef THERM_RAMP_SELFCHECK_EN
  output logic             all_zeros,
  output logic             err
`else
  output logic             all_zeros
`endif
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(WIDTH);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state, state_nxt;
  logic [LVL_W-1:0] tgt, tgt_nxt, level_nxt;
  logic             done_nxt;

  function automatic logic [WIDTH-1:0] to_therm(input logic [LVL_W-1:0] l);
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) t[i] = (i < int'(l));
    return t;
  endfunction

  assign tgt_ready = (state == IDLE);
  assign busy      = (state == RAMP);

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    level_nxt = level;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          tgt_nxt   = (tgt_level > MAX_LVL) ? MAX_LVL : tgt_level;
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (!hold) begin
          if (level < tgt) begin
            level_nxt = level + LVL_W'(1);
          end else if (level > tgt) begin
            level_nxt = level - LVL_W'(1);
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are registered from the next level so they always agree with therm_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      level     <= '0;
      therm_out <= '0;
      done      <= 1'b0;
      all_ones  <= 1'b0;
      all_zeros <= 1'b1;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      level     <= level_nxt;
      therm_out <= to_therm(level_nxt);
      done      <= done_nxt;
      all_ones  <= (level_nxt == MAX_LVL);
      all_zeros <= (level_nxt == '0);
    end
  end

`ifdef THERM_RAMP_SELFCHECK_EN
  logic [LVL_W-1:0] prev_level;
  logic [LVL_W-1:0] pop;
  logic             chk_bad;

  always_comb begin
    chk_bad = 1'b0;
    pop     = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (therm_out[i+1] && !therm_out[i]) chk_bad = 1'b1;
    end
    for (int i = 0; i < WIDTH; i++) pop = pop + LVL_W'(therm_out[i]);
    if (pop != level) chk_bad = 1'b1;
    // Extra bit so the +1 cannot wrap when WIDTH is at its upper limit.
    if ({1'b0, level} > {1'b0, prev_level} + (LVL_W+1)'(1)) chk_bad = 1'b1;
    if ({1'b0, prev_level} > {1'b0, level} + (LVL_W+1)'(1)) chk_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err        <= 1'b0;
      prev_level <= '0;
    end else begin
      err        <= err | chk_bad;
      prev_level <= level;
    end
  end
`endif

endmodule
